cmd_word_gate: RTL and testbench



---
 rtl/cmd_gate_pkg.sv | 14 +
 rtl/cmd_gate_timer.sv | 31 +++
 rtl/cmd_word_gate.sv | 126 ++++++++++++
 tb/tb_cmd_word_gate.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_gate_pkg.sv
// Shared types and constants for the command-word gate.
// Optional feature macro: CMD_GATE_TIMEOUT_EN (partial-word idle timeout).
package cmd_gate_pkg;

  localparam logic [31:0] FORBIDDEN_WORD = 32'hdeadbeef;

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } gate_state_e;

  typedef logic [1:0] byte_cnt_t;

endpackage

// File: rtl/cmd_gate_timer.sv
// Idle counter: counts enabled cycles and pulses o_expire on the cycle whose
// edge would bring the count to TIMEOUT_CYCLES, then restarts from zero.
// Used only when CMD_GATE_TIMEOUT_EN is defined.
module cmd_gate_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q;

  assign o_expire = i_en && !i_clr && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle cycle counter; clear wins over enable, expiry restarts the count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (i_clr || o_expire) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_word_gate.sv
// Assembles MSB-first bytes into 32-bit command words and never presents
// FORBIDDEN on o_word; rejected words are dropped and counted.
// Optional feature macro: CMD_GATE_TIMEOUT_EN (discard stale partial words).
module cmd_word_gate
  import cmd_gate_pkg::*;
#(
  parameter logic [31:0] FORBIDDEN      = FORBIDDEN_WORD,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [7:0]       i_byte,
  output logic             o_ready,
  output logic [31:0]      o_word,
  output logic             o_word_stb,
  output logic             o_reject_stb,
  output logic             o_resync,
  output logic [CNT_W-1:0] o_reject_cnt
);

  localparam bit PARAMS_OK = (TIMEOUT_CYCLES >= 2) && (FORBIDDEN != '0);

  gate_state_e      state_q;
  byte_cnt_t        cnt_q;
  logic [31:0]      sr_q;
  logic [31:0]      word_q;
  logic             ready_q;
  logic             word_stb_q;
  logic             reject_stb_q;
  logic             resync_q;
  logic [CNT_W-1:0] rej_cnt_q;
  logic             accept;
  logic             expire;

  assign accept = i_valid && ready_q;

`ifdef CMD_GATE_TIMEOUT_EN
  logic idle_en;
  logic idle_clr;

  assign idle_en  = (state_q == COLLECT) && (cnt_q != '0) && !accept;
  assign idle_clr = accept || (state_q != COLLECT) || (cnt_q == '0);

  cmd_gate_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (idle_clr),
    .i_en      (idle_en),
    .o_expire  (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Collect/evaluate FSM with all outputs registered; strobes default low.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      sr_q         <= '0;
      word_q       <= '0;
      ready_q      <= 1'b1;
      word_stb_q   <= 1'b0;
      reject_stb_q <= 1'b0;
      resync_q     <= 1'b0;
      rej_cnt_q    <= '0;
    end else begin
      word_stb_q   <= 1'b0;
      reject_stb_q <= 1'b0;
      resync_q     <= 1'b0;
      case (state_q)
        COLLECT: begin
          // An accepted byte outranks a same-edge timeout.
          if (accept) begin
            sr_q  <= {sr_q[23:0], i_byte};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= EVAL;
              ready_q <= 1'b0;
            end
          end else if (expire) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            resync_q <= 1'b1;
          end
        end
        EVAL: begin
          if (sr_q == FORBIDDEN) begin
            reject_stb_q <= 1'b1;
            if (rej_cnt_q != '1) begin
              rej_cnt_q <= rej_cnt_q + 1'b1;
            end
          end else begin
            word_q     <= sr_q;
            word_stb_q <= 1'b1;
          end
          cnt_q   <= '0;
          state_q <= COLLECT;
          ready_q <= 1'b1;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign o_ready      = ready_q;
  assign o_word       = word_q;
  assign o_word_stb   = word_stb_q;
  assign o_reject_stb = reject_stb_q;
  assign o_resync     = resync_q;
  assign o_reject_cnt = rej_cnt_q;

`ifndef SYNTHESIS
  a_params_ok: assert property (@(posedge i_clk) PARAMS_OK);
  a_no_forbidden: assert property (@(posedge i_clk) word_q != FORBIDDEN);
  a_strobes_onehot0: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0({word_stb_q, reject_stb_q, resync_q}));
  a_ready_low_only_eval: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !ready_q |-> (state_q == EVAL));
`endif

endmodule

// File: tb/tb_cmd_word_gate.sv
// Directed bench for cmd_word_gate; timeout steps depend on CMD_GATE_TIMEOUT_EN.
module tb_cmd_word_gate;

`ifdef CMD_GATE_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1000;
`endif
  localparam int unsigned CW = 2;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_valid;
  logic [7:0]    i_byte;
  logic          o_ready;
  logic [31:0]   o_word;
  logic          o_word_stb;
  logic          o_reject_stb;
  logic          o_resync;
  logic [CW-1:0] o_reject_cnt;

  int total = 0;
  int bad   = 0;

  cmd_word_gate #(
    .FORBIDDEN      (32'hdeadbeef),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_valid      (i_valid),
    .i_byte       (i_byte),
    .o_ready      (o_ready),
    .o_word       (o_word),
    .o_word_stb   (o_word_stb),
    .o_reject_stb (o_reject_stb),
    .o_resync     (o_resync),
    .o_reject_cnt (o_reject_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic pre;
    logic ok;
    ok      = 1'b0;
    i_valid = 1'b1;
    i_byte  = b;
    for (int n = 0; n < 8; n++) begin
      pre = o_ready;
      step();
      if (pre) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte_accepted", {31'b0, ok}, 32'd1);
  endtask

  // Caller has just had the 4th byte accepted: EVAL cycle, then exit edge.
  task automatic finish_word();
    i_valid = 1'b0;
    check("eval_ready_low", {31'b0, o_ready}, 32'd0);
    step();
  endtask

  task automatic send4(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    finish_word();
  endtask

  logic [7:0]  data [32];
  logic [31:0] got  [4];
  int          idx;
  int          nw;
  int          rs;
  logic        pre_rdy;

  initial begin
    i_reset_n = 1'b1;
    i_valid   = 1'b0;
    i_byte    = 8'h00;
    #1 i_reset_n = 1'b0;
    #11;
    check("rst_word",    o_word, 32'h0);
    check("rst_ready",   {31'b0, o_ready}, 32'd1);
    check("rst_strobes", {29'b0, o_word_stb, o_reject_stb, o_resync}, 32'd0);
    check("rst_cnt",     {30'b0, o_reject_cnt}, 32'd0);
    #1 i_reset_n = 1'b1;
    step();

    // First word, exact latency and single-cycle strobe.
    send4(32'h12345678);
    check("w1_word", o_word, 32'h12345678);
    check("w1_stb",  {31'b0, o_word_stb}, 32'd1);
    check("w1_ready_back", {31'b0, o_ready}, 32'd1);
    step();
    check("w1_stb_fall", {31'b0, o_word_stb}, 32'd0);

    // Same word again still strobes.
    send4(32'h12345678);
    check("w1_repeat_stb", {31'b0, o_word_stb}, 32'd1);
    check("w1_repeat_word", o_word, 32'h12345678);

    // Forbidden word is dropped and counted.
    send4(32'hdeadbeef);
    check("rej_word", o_word, 32'h12345678);
    check("rej_stb",  {31'b0, o_reject_stb}, 32'd1);
    check("rej_wstb", {31'b0, o_word_stb}, 32'd0);
    check("rej_cnt",  {30'b0, o_reject_cnt}, 32'd1);
    step();
    check("rej_stb_fall", {31'b0, o_reject_stb}, 32'd0);

    // Continuous stream: 4 bytes per 5 cycles, EVAL byte held over.
    for (int i = 0; i < 32; i++) data[i] = 8'h10 + 8'(i);
    idx = 0;
    nw  = 0;
    i_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i_byte  = data[idx];
      pre_rdy = o_ready;
      step();
      if (pre_rdy) idx++;
      if (o_word_stb) begin
        if (nw < 4) got[nw] = o_word;
        nw++;
      end
    end
    i_valid = 1'b0;
    check("stream_bytes", idx, 32'd16);
    check("stream_words", nw,  32'd4);
    check("stream_w0", got[0], 32'h10111213);
    check("stream_w1", got[1], 32'h14151617);
    check("stream_w2", got[2], 32'h18191a1b);
    check("stream_w3", got[3], 32'h1c1d1e1f);

`ifdef CMD_GATE_TIMEOUT_EN
    // Partial word discarded after TO idle cycles.
    send_byte(8'haa);
    send_byte(8'hbb);
    i_valid = 1'b0;
    repeat (TO - 1) step();
    check("to_early", {31'b0, o_resync}, 32'd0);
    step();
    check("to_resync", {31'b0, o_resync}, 32'd1);
    step();
    check("to_resync_fall", {31'b0, o_resync}, 32'd0);
    send4(32'h01020304);
    check("to_word", o_word, 32'h01020304);
    check("to_wstb", {31'b0, o_word_stb}, 32'd1);
`else
    // Partial word waits indefinitely.
    send_byte(8'haa);
    send_byte(8'hbb);
    i_valid = 1'b0;
    rs = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_resync) rs++;
    end
    check("idle_no_resync", rs, 32'd0);
    send_byte(8'hcc);
    send_byte(8'hdd);
    finish_word();
    check("idle_word", o_word, 32'haabbccdd);
    check("idle_wstb", {31'b0, o_word_stb}, 32'd1);
`endif

    // Asynchronous reset mid-word.
    send_byte(8'h33);
    send_byte(8'h44);
    i_valid = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    check("mid_rst_word",  o_word, 32'h0);
    check("mid_rst_ready", {31'b0, o_ready}, 32'd1);
    check("mid_rst_cnt",   {30'b0, o_reject_cnt}, 32'd0);
    #1 i_reset_n = 1'b1;
    rs = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_word_stb || o_reject_stb || o_resync) rs++;
    end
    check("mid_rst_no_stb", rs, 32'd0);
    send4(32'h55667788);
    check("post_rst_word", o_word, 32'h55667788);
    check("post_rst_wstb", {31'b0, o_word_stb}, 32'd1);

    // Reject counter saturation (2-bit counter).
    for (int k = 1; k <= 3; k++) begin
      send4(32'hdeadbeef);
      check("sat_cnt_ramp", {30'b0, o_reject_cnt}, 32'(k));
    end
    send4(32'hdeadbeef);
    check("sat_stb",  {31'b0, o_reject_stb}, 32'd1);
    check("sat_cnt",  {30'b0, o_reject_cnt}, 32'd3);
    check("sat_word", o_word, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
